// File: rtl/vga_text_renderer.sv
// 640x480@60 text renderer: 11x64 character window, external 8x16 font ROM,
// RGB332 output. Two-stage registered pipeline from the raster counters.
module vga_text_renderer #(
  parameter int unsigned X0        = 64,
  parameter int unsigned Y0        = 152,
  parameter logic [7:0]  FG_COLOR  = 8'hFF,
  parameter logic [7:0]  HDR_COLOR = 8'h1C,
  parameter logic [7:0]  BG_COLOR  = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data [0:703],
  output logic [11:0] font_addr,
  input  logic [7:0]  font_row,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [7:0]  rgb,
  output logic        frame_tick
);

  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] H_VISIBLE  = 10'd640;
  localparam logic [9:0] H_SYNC_BEG = 10'd656;
  localparam logic [9:0] H_SYNC_END = 10'd752;
  localparam logic [9:0] V_LAST     = 10'd524;
  localparam logic [9:0] V_VISIBLE  = 10'd480;
  localparam logic [9:0] V_SYNC_BEG = 10'd490;
  localparam logic [9:0] V_SYNC_END = 10'd492;

  localparam logic [9:0] X_LO = 10'(X0);
  localparam logic [9:0] X_HI = 10'(X0 + 512);
  localparam logic [9:0] Y_LO = 10'(Y0);
  localparam logic [9:0] Y_HI = 10'(Y0 + 176);

  localparam logic [7:0]  SPACE_CODE = 8'h20;
  localparam logic [11:0] BLANK_ADDR = 12'h200;

  // ---------------------------------------------------------------------------
  // S0: raster counters
  // ---------------------------------------------------------------------------
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its sources, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: window decode, character fetch, font address
  // ---------------------------------------------------------------------------
  logic        in_win_d;
  logic [8:0]  cx;
  logic [7:0]  cy;
  logic [3:0]  char_row;
  logic [5:0]  char_col;
  logic [9:0]  idx;
  logic [7:0]  raw_code;
  logic [7:0]  code;
  logic [11:0] font_addr_d;
  logic        header_d;
  logic        visible_d;
  logic        hsync_d;
  logic        vsync_d;
  logic        frame_d;

  always_comb begin
    in_win_d = (h_q >= X_LO) && (h_q < X_HI) && (v_q >= Y_LO) && (v_q < Y_HI);
    // Offsets are forced to zero outside the window so a negative difference
    // can never wrap around into a valid cell.
    cx       = in_win_d ? 9'(h_q - X_LO) : '0;
    cy       = in_win_d ? 8'(v_q - Y_LO) : '0;
    char_row = cy[7:4];
    char_col = cx[8:3];
    idx      = 10'(char_row) * 10'd64 + 10'(char_col);
    raw_code = data[idx];
    code     = ((raw_code < 8'h20) || (raw_code > 8'h7E)) ? SPACE_CODE : raw_code;
    font_addr_d = in_win_d ? {code, cy[3:0]} : BLANK_ADDR;
    header_d  = (char_row == 4'd0) || (char_row == 4'd6);
    visible_d = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);
    hsync_d   = !((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END));
    vsync_d   = !((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END));
    frame_d   = (h_q == '0) && (v_q == '0);
  end

  logic [11:0] font_addr_q;
  logic [2:0]  bit_sel_q;
  logic        in_win_q;
  logic        header_q;
  logic        visible_q;
  logic        hsync1_q;
  logic        vsync1_q;
  logic        frame1_q;

  // Sync flags reset to their inactive level so the first post-reset cycle
  // does not emit a spurious sync pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      font_addr_q <= '0;
      bit_sel_q   <= '0;
      in_win_q    <= 1'b0;
      header_q    <= 1'b0;
      visible_q   <= 1'b0;
      hsync1_q    <= 1'b1;
      vsync1_q    <= 1'b1;
      frame1_q    <= 1'b0;
    end else begin
      font_addr_q <= font_addr_d;
      bit_sel_q   <= cx[2:0];
      in_win_q    <= in_win_d;
      header_q    <= header_d;
      visible_q   <= visible_d;
      hsync1_q    <= hsync_d;
      vsync1_q    <= vsync_d;
      frame1_q    <= frame_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: pixel colour; font_row answers the address registered in S1
  // ---------------------------------------------------------------------------
  logic       pixel_bit;
  logic [7:0] rgb_d;

  always_comb begin
    pixel_bit = font_row[3'd7 - bit_sel_q];
    rgb_d     = 8'h00;
    if (visible_q && in_win_q) begin
      if (pixel_bit) rgb_d = header_q ? HDR_COLOR : FG_COLOR;
      else           rgb_d = BG_COLOR;
    end
  end

  logic [7:0] rgb_q;
  logic       hsync_q;
  logic       vsync_q;
  logic       blank_n_q;
  logic       frame_tick_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q        <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      blank_n_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      rgb_q        <= rgb_d;
      hsync_q      <= hsync1_q;
      vsync_q      <= vsync1_q;
      blank_n_q    <= visible_q;
      frame_tick_q <= frame1_q;
    end
  end

  assign font_addr  = font_addr_q;
  assign rgb        = rgb_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign blank_n    = blank_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Scoreboard bench for vga_text_renderer: expectations are queued against the
// cycle count since reset release and checked by an independent monitor.
module tb_vga_text_renderer;

  typedef enum logic [2:0] {
    SIG_HSYNC, SIG_VSYNC, SIG_BLANK, SIG_RGB, SIG_TICK, SIG_ADDR
  } sig_e;

  typedef struct {
    int unsigned cyc;
    sig_e        sig;
    logic [11:0] exp;
    string       name;
  } item_t;

  logic        clk;
  logic        reset;
  logic [7:0]  data [0:703];
  logic [11:0] font_addr;
  logic [7:0]  font_row;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic [7:0]  rgb;
  logic        frame_tick;

  item_t       sb_q[$];
  int unsigned k;
  int          checks;
  int          errors;

  vga_text_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .font_addr  (font_addr),
    .font_row   (font_row),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank_n    (blank_n),
    .rgb        (rgb),
    .frame_tick (frame_tick)
  );

  // Font ROM model: every glyph line is solid except the two patterned ones.
  function automatic logic [7:0] rom_f(input logic [11:0] a);
    case (a)
      12'h540: return 8'h80;
      12'h41F: return 8'h01;
      default: return 8'hFF;
    endcase
  endfunction

  assign font_row = rom_f(font_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int unsigned pos(input int x, input int y);
    return int'(y) * 800 + x;
  endfunction

  function automatic logic [11:0] actual(input sig_e s);
    case (s)
      SIG_HSYNC: return {11'd0, hsync};
      SIG_VSYNC: return {11'd0, vsync};
      SIG_BLANK: return {11'd0, blank_n};
      SIG_RGB:   return {4'd0, rgb};
      SIG_TICK:  return {11'd0, frame_tick};
      default:   return font_addr;
    endcase
  endfunction

  task automatic push(input int unsigned cyc, input sig_e sig, input logic [11:0] e,
                      input string name);
    item_t it;
    int    i;
    it.cyc  = cyc;
    it.sig  = sig;
    it.exp  = e;
    it.name = name;
    i = sb_q.size();
    while (i > 0 && sb_q[i-1].cyc > cyc) i--;
    sb_q.insert(i, it);
  endtask

  // Output pins show pixel (x,y) two cycles after the counter held it.
  task automatic exp_px(input int x, input int y, input sig_e s, input logic [11:0] e);
    push(pos(x, y) + 2, s, e, $sformatf("%s@%0d,%0d", s.name(), x, y));
  endtask

  task automatic exp_addr(input int x, input int y, input logic [11:0] e);
    push(pos(x, y) + 1, SIG_ADDR, e, $sformatf("ADDR@%0d,%0d", x, y));
  endtask

  task automatic push_reset_checks();
    push(0, SIG_HSYNC, 12'h1, "rst_hsync");
    push(0, SIG_VSYNC, 12'h1, "rst_vsync");
    push(0, SIG_BLANK, 12'h0, "rst_blank_n");
    push(0, SIG_RGB,   12'h0, "rst_rgb");
    push(0, SIG_TICK,  12'h0, "rst_frame_tick");
    push(0, SIG_ADDR,  12'h0, "rst_font_addr");
  endtask

  task automatic wait_k(input int unsigned target);
    int n;
    int budget;
    n = 0;
    budget = int'(target - k) + 100;
    while (k < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (k < target) begin
      errors++;
      $display("FAIL wait_k: reached cycle %0d, required %0d", k, target);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      errors += sb_q.size();
      $display("FAIL %s: %0d expectations never checked, required 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: k counts posedges since reset release; compares at the negedge.
  initial begin
    item_t       it;
    logic [11:0] act;
    k = 0;
    forever begin
      @(posedge clk);
      if (reset) k = 0;
      else       k++;
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= k) begin
        it  = sb_q.pop_front();
        act = actual(it.sig);
        checks++;
        if (it.cyc < k) begin
          errors++;
          $display("FAIL %s: missed at cycle %0d, required cycle %0d", it.name, k, it.cyc);
        end else if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %0h, expected %0h", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    for (int i = 0; i < 704; i++) data[i] = 8'h20;
    data[0]   = 8'h54;
    data[99]  = 8'h41;
    data[100] = 8'h07;
    data[101] = 8'h7F;
    data[102] = 8'h7E;
    data[103] = 8'h1F;
    data[703] = 8'h41;
    push_reset_checks();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Start of the first frame, then a reset in the middle of line 2's hsync.
    exp_px(0, 0, SIG_TICK, 12'h1);
    exp_px(1, 0, SIG_TICK, 12'h0);
    exp_px(0, 0, SIG_BLANK, 12'h1);
    exp_px(656, 0, SIG_HSYNC, 12'h0);
    exp_px(700, 2, SIG_HSYNC, 12'h0);
    wait_k(pos(700, 2) + 2);
    wait_drain("pre_reset");
    reset = 1'b1;
    @(posedge clk);
    push_reset_checks();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Timing after the restart.
    exp_px(0, 0, SIG_TICK, 12'h1);
    exp_px(1, 0, SIG_TICK, 12'h0);
    exp_px(0, 1, SIG_TICK, 12'h0);
    exp_px(0, 0, SIG_VSYNC, 12'h1);
    exp_addr(0, 0, 12'h200);
    for (int x = 0; x < 800; x++)
      exp_px(x, 0, SIG_HSYNC, (x >= 656 && x < 752) ? 12'h0 : 12'h1);
    for (int x = 0; x < 800; x++)
      exp_px(x, 1, SIG_BLANK, (x < 640) ? 12'h1 : 12'h0);

    // Window edges and header glyph.
    for (int x = 0; x < 640; x++) exp_px(x, 151, SIG_RGB, 12'h00);
    exp_addr(64, 151, 12'h200);
    exp_addr(63, 152, 12'h200);
    exp_px(63, 152, SIG_RGB, 12'h00);
    exp_addr(64, 152, 12'h540);
    exp_px(64, 152, SIG_RGB, 12'h1C);
    exp_px(65, 152, SIG_RGB, 12'h00);
    exp_px(71, 152, SIG_RGB, 12'h00);
    exp_addr(72, 152, 12'h200);
    exp_px(72, 152, SIG_RGB, 12'h1C);

    // Row 1, glyph line 2: substitution of out-of-range codes.
    exp_addr(344, 170, 12'h412);
    exp_px(344, 170, SIG_RGB, 12'hFF);
    exp_addr(352, 170, 12'h202);
    exp_addr(360, 170, 12'h202);
    exp_addr(368, 170, 12'h7E2);
    exp_addr(376, 170, 12'h202);
    exp_addr(384, 170, 12'h202);
    exp_px(575, 200, SIG_RGB, 12'hFF);
    exp_px(63, 200, SIG_RGB, 12'h00);
    for (int y = 152; y < 328; y++) exp_px(576, y, SIG_RGB, 12'h00);

    // Header row 6 between body rows 5 and 7.
    exp_px(100, 247, SIG_RGB, 12'hFF);
    exp_px(100, 248, SIG_RGB, 12'h1C);
    exp_px(100, 264, SIG_RGB, 12'hFF);
    exp_px(656, 100, SIG_HSYNC, 12'h0);

    // Whole buffer forced to 8'h7F from line 270.
    exp_addr(64, 280, 12'h200);
    exp_px(64, 280, SIG_RGB, 12'hFF);
    exp_addr(200, 285, 12'h205);
    for (int x = 64; x < 576; x += 8) exp_addr(x, 290, 12'h20A);
    exp_addr(568, 295, 12'h20F);

    // Last cell restored to 'A' from line 300.
    exp_addr(575, 326, 12'h41E);
    exp_px(575, 326, SIG_RGB, 12'hFF);
    exp_addr(567, 327, 12'h20F);
    exp_addr(568, 327, 12'h41F);
    exp_px(568, 327, SIG_RGB, 12'h00);
    exp_px(574, 327, SIG_RGB, 12'h00);
    exp_addr(575, 327, 12'h41F);
    exp_px(575, 327, SIG_RGB, 12'hFF);
    exp_addr(576, 327, 12'h200);
    exp_px(576, 327, SIG_RGB, 12'h00);
    for (int x = 64; x < 576; x++) exp_px(x, 328, SIG_RGB, 12'h00);

    // Vertical blanking and sync.
    exp_px(0, 479, SIG_BLANK, 12'h1);
    exp_px(639, 479, SIG_BLANK, 12'h1);
    for (int y = 480; y < 525; y++) begin
      exp_px(0, y, SIG_BLANK, 12'h0);
      exp_px(639, y, SIG_BLANK, 12'h0);
    end
    exp_px(799, 489, SIG_VSYNC, 12'h1);
    for (int y = 490; y < 492; y++)
      for (int x = 0; x < 800; x++) exp_px(x, y, SIG_VSYNC, 12'h0);
    exp_px(0, 492, SIG_VSYNC, 12'h1);
    exp_px(799, 524, SIG_VSYNC, 12'h1);

    // Next frame: tick exactly 420000 cycles after the first one.
    exp_px(799, 524, SIG_TICK, 12'h0);
    exp_px(0, 525, SIG_TICK, 12'h1);
    exp_px(1, 525, SIG_TICK, 12'h0);
    exp_px(0, 525, SIG_BLANK, 12'h1);

    wait_k(pos(0, 270));
    for (int i = 0; i < 704; i++) data[i] = 8'h7F;
    wait_k(pos(0, 300));
    data[703] = 8'h41;
    wait_k(pos(2, 525) + 2);
    wait_drain("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
